icache_unit: RTL

- Direct-mapped instruction cache: the responder end of the instruction-fetch request/response interface.
- Accepts single-word fetch requests (`request_t`) from the fetch unit and returns one 64-bit word per request (opcode0 = `data[31:0]`, opcode1 = `data[63:32]`).
- On a miss it stalls the fetch side via `icache_busy` and refills one line from memory with a single burst read.
- Sits between the fetch unit and the core's memory/NoC port.

---
 rtl/icache_unit_pkg.sv | 29 ++
 rtl/icache_unit_data_array.sv | 58 +++++
 rtl/icache_unit.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/icache_unit_pkg.sv
// Shared types for the instruction cache: the fetch/memory request record,
// access kinds and the refill FSM state encoding.
package icache_unit_pkg;

    localparam int ADDR_FIELD_WIDTH = 32;
    localparam int DATA_FIELD_WIDTH = 128;
    localparam int LEN_FIELD_WIDTH  = 8;

    typedef enum logic [1:0] {
        NULL_ACCESS  = 2'd0,
        READ_ACCESS  = 2'd1,
        WRITE_ACCESS = 2'd2
    } access_t;

    typedef struct packed {
        logic                        vld;
        access_t                     access_type;
        logic [ADDR_FIELD_WIDTH-1:0] addr;
        logic [LEN_FIELD_WIDTH-1:0]  access_length;
        logic [DATA_FIELD_WIDTH-1:0] data;
    } request_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MISS_REQ = 2'd1,
        FILL     = 2'd2
    } icache_state_t;

endpackage

// File: rtl/icache_unit_data_array.sv
// Tag, valid and data storage for the direct-mapped cache: synchronous writes,
// combinational read on (idx, off), one-cycle clear of every valid bit.
import icache_unit_pkg::*;

module icache_unit_data_array #(
    parameter int NUM_LINES  = 64,
    parameter int LINE_WORDS = 4,
    parameter int IDX_W      = $clog2(NUM_LINES),
    parameter int OFF_W      = $clog2(LINE_WORDS),
    parameter int TAG_W      = ADDR_FIELD_WIDTH - IDX_W - OFF_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_flush,
    input  logic [IDX_W-1:0] i_rd_idx,
    input  logic [OFF_W-1:0] i_rd_off,
    output logic             o_rd_valid,
    output logic [TAG_W-1:0] o_rd_tag,
    output logic [63:0]      o_rd_data,
    input  logic             i_wr_en,
    input  logic [IDX_W-1:0] i_wr_idx,
    input  logic [OFF_W-1:0] i_wr_off,
    input  logic [63:0]      i_wr_data,
    input  logic             i_tag_we,
    input  logic [TAG_W-1:0] i_tag,
    input  logic             i_set_valid
);

    logic [NUM_LINES-1:0] r_valid;
    logic [TAG_W-1:0]     r_tag  [NUM_LINES];
    logic [63:0]          r_data [NUM_LINES*LINE_WORDS];

    assign o_rd_valid = r_valid[i_rd_idx];
    assign o_rd_tag   = r_tag[i_rd_idx];
    assign o_rd_data  = r_data[{i_rd_idx, i_rd_off}];

    // A tag write always rewrites the valid bit, so a refill that saw a flush
    // leaves the line invalid rather than keeping a stale valid bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid <= '0;
        end else if (i_flush) begin
            r_valid <= '0;
        end else if (i_tag_we) begin
            r_valid[i_wr_idx] <= i_set_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (i_tag_we) begin
            r_tag[i_wr_idx] <= i_tag;
        end
        if (i_wr_en) begin
            r_data[{i_wr_idx, i_wr_off}] <= i_wr_data;
        end
    end

endmodule

// File: rtl/icache_unit.sv
// Direct-mapped instruction cache: answers fetch requests in one cycle on a hit,
// stalls the fetch side and refills a whole line with one burst on a miss.
import icache_unit_pkg::*;

module icache_unit #(
    parameter int NUM_LINES  = 64,
    parameter int LINE_WORDS = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  request_t      icache_req,
    output logic          icache_busy,
    output request_t      icache_rsp,
    output request_t      mem_req,
    input  logic          mem_busy,
    input  request_t      mem_rsp,
    output icache_state_t o_state
);

    localparam int OFF_W = $clog2(LINE_WORDS);
    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = ADDR_FIELD_WIDTH - IDX_W - OFF_W;

    localparam logic [1:0] ST_IDLE     = IDLE;
    localparam logic [1:0] ST_MISS_REQ = MISS_REQ;
    localparam logic [1:0] ST_FILL     = FILL;

    localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINE_WORDS - 1);

    logic [1:0]                  r_state;
    logic [ADDR_FIELD_WIDTH-1:0] r_line_addr;
    logic [OFF_W-1:0]            r_beat_cnt;
    logic                        r_flush_pending;
    request_t                    r_rsp;

    logic [IDX_W-1:0] w_req_idx;
    logic [OFF_W-1:0] w_req_off;
    logic [TAG_W-1:0] w_req_tag;
    logic             w_rd_valid;
    logic [TAG_W-1:0] w_rd_tag;
    logic [63:0]      w_rd_data;
    logic             w_hit;
    logic [IDX_W-1:0] w_fill_idx;
    logic [TAG_W-1:0] w_fill_tag;
    logic             w_beat_fire;
    logic             w_last_beat;
    logic             w_set_valid;
    logic             w_unused_ok;

    assign w_req_off  = icache_req.addr[OFF_W-1:0];
    assign w_req_idx  = icache_req.addr[OFF_W +: IDX_W];
    assign w_req_tag  = icache_req.addr[ADDR_FIELD_WIDTH-1:OFF_W+IDX_W];
    assign w_fill_idx = r_line_addr[OFF_W +: IDX_W];
    assign w_fill_tag = r_line_addr[ADDR_FIELD_WIDTH-1:OFF_W+IDX_W];

    assign w_hit       = w_rd_valid && (w_rd_tag == w_req_tag);
    assign w_beat_fire = (r_state == ST_FILL) && mem_rsp.vld;
    assign w_last_beat = w_beat_fire && (r_beat_cnt == LAST_BEAT);
    assign w_set_valid = !(r_flush_pending || flush);

    // Fetch side: a request transfers on an edge where vld && !icache_busy;
    // the requester holds vld/addr while busy. Busy is combinational on the
    // request so a missing request is never consumed. Memory side: mem_req
    // transfers on an edge where mem_req.vld && !mem_busy, and vld is only
    // raised in a cycle where mem_busy is low.
    assign icache_busy = (r_state != ST_IDLE) || (icache_req.vld && !w_hit);
    assign icache_rsp  = r_rsp;
    assign o_state     = icache_state_t'(r_state);

    assign w_unused_ok = ^{icache_req.access_type, icache_req.access_length,
                           icache_req.data, mem_rsp.access_type, mem_rsp.addr,
                           mem_rsp.access_length,
                           mem_rsp.data[DATA_FIELD_WIDTH-1:64]};

    always_comb begin
        mem_req = '0;
        if ((r_state == ST_MISS_REQ) && !mem_busy) begin
            mem_req.vld           = 1'b1;
            mem_req.access_type   = READ_ACCESS;
            mem_req.addr          = r_line_addr;
            mem_req.access_length = LEN_FIELD_WIDTH'(LINE_WORDS - 1);
        end
    end

    icache_unit_data_array #(
        .NUM_LINES (NUM_LINES),
        .LINE_WORDS(LINE_WORDS),
        .IDX_W     (IDX_W),
        .OFF_W     (OFF_W),
        .TAG_W     (TAG_W)
    ) u_data_array (
        .clk        (clk),
        .reset      (reset),
        .i_flush    (flush),
        .i_rd_idx   (w_req_idx),
        .i_rd_off   (w_req_off),
        .o_rd_valid (w_rd_valid),
        .o_rd_tag   (w_rd_tag),
        .o_rd_data  (w_rd_data),
        .i_wr_en    (w_beat_fire),
        .i_wr_idx   (w_fill_idx),
        .i_wr_off   (r_beat_cnt),
        .i_wr_data  (mem_rsp.data[63:0]),
        .i_tag_we   (w_last_beat),
        .i_tag      (w_fill_tag),
        .i_set_valid(w_set_valid)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state         <= ST_IDLE;
            r_line_addr     <= '0;
            r_beat_cnt      <= '0;
            r_flush_pending <= 1'b0;
            r_rsp           <= '0;
        end else begin
            r_rsp <= '0;
            // A flush while a refill is in flight must keep that line invalid.
            if (w_last_beat) begin
                r_flush_pending <= 1'b0;
            end else if (flush && (r_state != ST_IDLE)) begin
                r_flush_pending <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (icache_req.vld) begin
                        if (w_hit) begin
                            r_rsp.vld         <= 1'b1;
                            r_rsp.access_type <= NULL_ACCESS;
                            r_rsp.addr        <= icache_req.addr;
                            r_rsp.data        <= DATA_FIELD_WIDTH'(w_rd_data);
                        end else begin
                            r_line_addr <= {icache_req.addr[ADDR_FIELD_WIDTH-1:OFF_W],
                                            {OFF_W{1'b0}}};
                            r_state     <= ST_MISS_REQ;
                        end
                    end
                end
                ST_MISS_REQ: begin
                    if (!mem_busy) begin
                        r_state <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    if (w_beat_fire) begin
                        r_beat_cnt <= r_beat_cnt + OFF_W'(1);
                        if (w_last_beat) begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
